// File: rtl/spi_engine_cmd_pkg.sv
// Shared opcodes, FSM state and transfer-direction types for the SPI Engine command builder.
// States CFG/PRESCALE exist only when SPI_CMD_BUILDER_CFG_EN is defined.
package spi_engine_cmd_pkg;

    localparam logic [7:0] OP_CS       = 8'h10;
    localparam logic [7:0] OP_CFG      = 8'h21;
    localparam logic [7:0] OP_PRESCALE = 8'h20;
    localparam logic [7:0] OP_DLEN     = 8'h22;
    localparam logic [7:0] OP_SYNC     = 8'h30;
    localparam logic [7:0] OP_SLEEP    = 8'h31;
    localparam logic [7:0] OP_WR       = 8'h01;
    localparam logic [7:0] OP_RD       = 8'h02;
    localparam logic [7:0] OP_WRD      = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE,
`ifdef SPI_CMD_BUILDER_CFG_EN
        ST_CFG,
        ST_PRESCALE,
`endif
        ST_DLEN,
        ST_CS_ON,
        ST_XFER,
        ST_SLEEP,
        ST_CS_OFF,
        ST_SYNC
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_WR   = 2'b01,
        DIR_RD   = 2'b10,
        DIR_WRD  = 2'b11
    } dir_t;

    function automatic logic [7:0] xfer_opcode(input dir_t dir);
        logic [7:0] op;
        op = 8'h00;
        case (dir)
            DIR_WR:  op = OP_WR;
            DIR_RD:  op = OP_RD;
            DIR_WRD: op = OP_WRD;
            default: op = 8'h00;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/spi_engine_cmd_chunker.sv
// Remaining-word counter: splits a transfer into chunks of at most 256 words and
// reports the current chunk's n-1, the chunk after it, and whether the current one is last.
module spi_engine_cmd_chunker #(
    parameter int WORDS_W = 12
) (
    input  logic               clk,
    input  logic               load,
    input  logic [WORDS_W-1:0] load_words,
    input  logic               advance,
    output logic [7:0]         chunk_m1,
    output logic               last,
    output logic [7:0]         nxt_chunk_m1
);

    logic [WORDS_W-1:0] rem_q;
    logic [WORDS_W-1:0] rem_d;
    logic [31:0]        rem_w;
    logic [31:0]        nxt_w;

    always_comb begin
        rem_w        = 32'(rem_q);
        nxt_w        = rem_w - 32'd256;
        last         = (rem_w <= 32'd256);
        chunk_m1     = last ? 8'(rem_w - 32'd1) : 8'hFF;
        // Only consumed when the current chunk is not the last, so nxt_w never underflows there.
        nxt_chunk_m1 = (nxt_w <= 32'd256) ? 8'(nxt_w - 32'd1) : 8'hFF;
        rem_d        = rem_q;
        if (load) begin
            rem_d = load_words;
        end else if (advance) begin
            rem_d = WORDS_W'(nxt_w);
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
    end

endmodule

// File: rtl/spi_engine_cmd_builder.sv
// Expands one transfer request into an SPI Engine instruction stream with registered outputs.
// Define SPI_CMD_BUILDER_CFG_EN to add the CFG/PRESCALE prologue and its cfg_* ports.
module spi_engine_cmd_builder
    import spi_engine_cmd_pkg::*;
#(
    parameter int NUM_OF_CS = 1,
    parameter int WORDS_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_cs_sel,
    input  logic [1:0]         req_dir,
    input  logic [WORDS_W-1:0] req_words,
    input  logic [7:0]         req_dlength,
    input  logic [1:0]         req_cs_delay,
    input  logic [7:0]         req_sleep,
    input  logic [7:0]         req_sync_id,
`ifdef SPI_CMD_BUILDER_CFG_EN
    input  logic               cfg_cpol,
    input  logic               cfg_cpha,
    input  logic               cfg_three_wire,
    input  logic               cfg_sdo_idle,
    input  logic [7:0]         cfg_prescale,
`endif
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [15:0]        cmd_data,
    output logic               busy
);

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [15:0]        cmd_data_q, cmd_data_d;
    logic [7:0]         cache_q, cache_d;
    logic               cache_vld_q, cache_vld_d;

    logic [2:0]         sel_q;
    dir_t               dir_q;
    logic [WORDS_W-1:0] words_q;
    logic [7:0]         dlen_q, sleep_q, id_q;
    logic [1:0]         delay_q;
`ifdef SPI_CMD_BUILDER_CFG_EN
    logic [7:0]         prescale_q;
`endif

    logic               accept, hs;
    logic [2:0]         f_sel;
    dir_t               f_dir;
    logic [WORDS_W-1:0] f_words;
    logic [7:0]         f_dlen, f_sleep, f_id;
    logic [1:0]         f_delay;
    logic               cs_ok, need_dlen, do_xfer;
    state_t             after_pre, after_cs, after_xfer;
    logic [7:0]         chunk_m1, nxt_chunk_m1;
    logic               chunk_last, chunk_adv;

    spi_engine_cmd_chunker #(.WORDS_W(WORDS_W)) u_chunker (
        .clk          (clk),
        .load         (accept),
        .load_words   (req_words),
        .advance      (chunk_adv),
        .chunk_m1     (chunk_m1),
        .last         (chunk_last),
        .nxt_chunk_m1 (nxt_chunk_m1)
    );

    always_comb begin
        accept    = req_valid && ready_q;
        hs        = cmd_valid_q && cmd_ready;
        chunk_adv = (state_q == ST_XFER) && hs;

        // Skip decisions are made on the accept cycle too, so read the request directly then.
        f_sel   = accept ? req_cs_sel          : sel_q;
        f_dir   = accept ? dir_t'(req_dir)     : dir_q;
        f_words = accept ? req_words           : words_q;
        f_dlen  = accept ? req_dlength         : dlen_q;
        f_delay = accept ? req_cs_delay        : delay_q;
        f_sleep = accept ? req_sleep           : sleep_q;
        f_id    = accept ? req_sync_id         : id_q;

        cs_ok      = (int'(f_sel) < NUM_OF_CS);
        need_dlen  = cs_ok && (f_dir != DIR_NONE) && (!cache_vld_q || (f_dlen != cache_q));
        do_xfer    = cs_ok && (f_dir != DIR_NONE) && (f_words != '0);
        after_xfer = (f_sleep != 8'd0) ? ST_SLEEP : ST_CS_OFF;
        after_cs   = do_xfer ? ST_XFER : after_xfer;
        after_pre  = need_dlen ? ST_DLEN : (cs_ok ? ST_CS_ON : ST_SYNC);

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef SPI_CMD_BUILDER_CFG_EN
                    state_d = ST_CFG;
`else
                    state_d = after_pre;
`endif
                end
            end
`ifdef SPI_CMD_BUILDER_CFG_EN
            ST_CFG:      if (hs) state_d = ST_PRESCALE;
            ST_PRESCALE: if (hs) state_d = after_pre;
`endif
            ST_DLEN:     if (hs) state_d = ST_CS_ON;
            ST_CS_ON:    if (hs) state_d = after_cs;
            ST_XFER:     if (hs) state_d = chunk_last ? after_xfer : ST_XFER;
            ST_SLEEP:    if (hs) state_d = ST_CS_OFF;
            ST_CS_OFF:   if (hs) state_d = ST_SYNC;
            ST_SYNC:     if (hs) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Load the next word on the same edge the current one is taken, keeping the stream bubble-free.
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        if (accept || hs) begin
            cmd_valid_d = (state_d != ST_IDLE);
            case (state_d)
`ifdef SPI_CMD_BUILDER_CFG_EN
                ST_CFG:      cmd_data_d = {OP_CFG, 4'b0000, cfg_sdo_idle, cfg_three_wire,
                                           cfg_cpol, cfg_cpha};
                ST_PRESCALE: cmd_data_d = {OP_PRESCALE, prescale_q};
`endif
                ST_DLEN:     cmd_data_d = {OP_DLEN, f_dlen};
                ST_CS_ON:    cmd_data_d = {OP_CS[7:2], f_delay, ~(8'd1 << f_sel)};
                ST_XFER:     cmd_data_d = {xfer_opcode(f_dir),
                                           (state_q == ST_XFER) ? nxt_chunk_m1 : chunk_m1};
                ST_SLEEP:    cmd_data_d = {OP_SLEEP, f_sleep};
                ST_CS_OFF:   cmd_data_d = {OP_CS[7:2], f_delay, 8'hFF};
                ST_SYNC:     cmd_data_d = {OP_SYNC, f_id};
                default:     cmd_data_d = cmd_data_q;
            endcase
        end

        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        if ((state_q == ST_DLEN) && hs) begin
            cache_d     = dlen_q;
            cache_vld_d = 1'b1;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= 16'h0000;
            cache_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            cache_vld_q <= cache_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        cache_q <= cache_d;
        if (accept) begin
            sel_q   <= req_cs_sel;
            dir_q   <= dir_t'(req_dir);
            words_q <= req_words;
            dlen_q  <= req_dlength;
            delay_q <= req_cs_delay;
            sleep_q <= req_sleep;
            id_q    <= req_sync_id;
`ifdef SPI_CMD_BUILDER_CFG_EN
            prescale_q <= cfg_prescale;
`endif
        end
    end

    assign req_ready = ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_engine_cmd_builder.sv
// Self-checking bench: directed vector table, reset/abort sequence, single-CS instance,
// and randomized requests with random cmd_ready stalls against a behavioural model.
module tb_spi_engine_cmd_builder;

    localparam int NCS = 4;

    typedef struct {
        logic [2:0]  sel;
        logic [1:0]  dir;
        logic [11:0] words;
        logic [7:0]  dlen;
        logic [1:0]  delay;
        logic [7:0]  sleep;
        logic [7:0]  id;
    } req_t;

    typedef struct {
        req_t        r;
        int          n;
        logic [15:0] w [8];
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid1;
    logic [2:0]  req_cs_sel;
    logic [1:0]  req_dir;
    logic [11:0] req_words;
    logic [7:0]  req_dlength;
    logic [1:0]  req_cs_delay;
    logic [7:0]  req_sleep;
    logic [7:0]  req_sync_id;
    logic        cmd_ready;
    logic        cmd_ready1 = 1'b1;
    logic        req_ready, cmd_valid, busy;
    logic [15:0] cmd_data;
    logic        req_ready1, cmd_valid1, busy1;
    logic [15:0] cmd_data1;
    bit          stall_en = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    logic [15:0] got1_q [$];
    logic [7:0]  mc;
    bit          mc_vld = 1'b0;
    vec_t        vt [8];

    always #5 clk = ~clk;

    spi_engine_cmd_builder #(.NUM_OF_CS(NCS), .WORDS_W(12)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cs_sel(req_cs_sel), .req_dir(req_dir), .req_words(req_words),
        .req_dlength(req_dlength), .req_cs_delay(req_cs_delay), .req_sleep(req_sleep),
        .req_sync_id(req_sync_id), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .busy(busy)
    );

    spi_engine_cmd_builder #(.NUM_OF_CS(1), .WORDS_W(12)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_cs_sel(req_cs_sel), .req_dir(req_dir), .req_words(req_words),
        .req_dlength(req_dlength), .req_cs_delay(req_cs_delay), .req_sleep(req_sleep),
        .req_sync_id(req_sync_id), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_data(cmd_data1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected instruction stream for one request, derived straight from the rules.
    task automatic model(input req_t r);
        int rem;
        exp_q.delete();
        if (int'(r.sel) < NCS) begin
            if (r.dir != 2'b00 && (!mc_vld || r.dlen != mc)) begin
                exp_q.push_back(16'h2200 | 16'(r.dlen));
                mc     = r.dlen;
                mc_vld = 1'b1;
            end
            exp_q.push_back(16'h1000 | (16'(r.delay) << 8) | (16'h00FF & ~(16'd1 << r.sel)));
            if (r.dir != 2'b00 && r.words != 12'd0) begin
                rem = int'(r.words);
                while (rem > 256) begin
                    exp_q.push_back((16'(r.dir) << 8) | 16'h00FF);
                    rem -= 256;
                end
                exp_q.push_back((16'(r.dir) << 8) | 16'(rem - 1));
            end
            if (r.sleep != 8'd0) exp_q.push_back(16'h3100 | 16'(r.sleep));
            exp_q.push_back(16'h1000 | (16'(r.delay) << 8) | 16'h00FF);
        end
        exp_q.push_back(16'h3000 | 16'(r.id));
    endtask

    task automatic drive_fields(input req_t r);
        req_cs_sel   = r.sel;
        req_dir      = r.dir;
        req_words    = r.words;
        req_dlength  = r.dlen;
        req_cs_delay = r.delay;
        req_sleep    = r.sleep;
        req_sync_id  = r.id;
    endtask

    task automatic send_req(input req_t r);
        int t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        drive_fields(r);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic compare_got(input string name);
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bit          stall_prev = 1'b0;
        logic [15:0] prev_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (stall_prev) begin
                    chk("stall_hold_valid", 32'(cmd_valid), 32'd1);
                    chk("stall_hold_data", 32'(cmd_data), 32'(prev_data));
                end
                if (cmd_valid && cmd_ready) begin
                    got_q.push_back(cmd_data);
                    chk("busy_while_valid", 32'(busy), 32'd1);
                end
                if (cmd_valid1 && cmd_ready1) got1_q.push_back(cmd_data1);
                stall_prev = cmd_valid && !cmd_ready;
                prev_data  = cmd_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        int   t;

        vt[0].r = '{3'd0, 2'b01, 12'd4,   8'h08, 2'd0, 8'h00, 8'h5A};
        vt[0].n = 5;
        vt[0].w = '{16'h2208, 16'h10FE, 16'h0103, 16'h10FF, 16'h305A, 16'h0, 16'h0, 16'h0};
        vt[1].r = '{3'd0, 2'b01, 12'd4,   8'h08, 2'd0, 8'h00, 8'h5A};
        vt[1].n = 4;
        vt[1].w = '{16'h10FE, 16'h0103, 16'h10FF, 16'h305A, 16'h0, 16'h0, 16'h0, 16'h0};
        vt[2].r = '{3'd2, 2'b11, 12'd600, 8'h10, 2'd1, 8'h03, 8'hA5};
        vt[2].n = 8;
        vt[2].w = '{16'h2210, 16'h11FB, 16'h03FF, 16'h03FF, 16'h0357, 16'h3103, 16'h11FF, 16'h30A5};
        vt[3].r = '{3'd5, 2'b01, 12'd4,   8'h08, 2'd0, 8'h00, 8'h11};
        vt[3].n = 1;
        vt[3].w = '{16'h3011, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vt[4].r = '{3'd0, 2'b10, 12'd256, 8'h08, 2'd3, 8'h00, 8'h01};
        vt[4].n = 5;
        vt[4].w = '{16'h2208, 16'h13FE, 16'h02FF, 16'h13FF, 16'h3001, 16'h0, 16'h0, 16'h0};
        vt[5].r = '{3'd3, 2'b01, 12'd257, 8'h08, 2'd0, 8'hFF, 8'h02};
        vt[5].n = 6;
        vt[5].w = '{16'h10F7, 16'h01FF, 16'h0100, 16'h31FF, 16'h10FF, 16'h3002, 16'h0, 16'h0};
        vt[6].r = '{3'd1, 2'b00, 12'd5,   8'h40, 2'd0, 8'h00, 8'h03};
        vt[6].n = 3;
        vt[6].w = '{16'h10FD, 16'h10FF, 16'h3003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vt[7].r = '{3'd0, 2'b01, 12'd0,   8'h08, 2'd0, 8'h00, 8'h04};
        vt[7].n = 3;
        vt[7].w = '{16'h10FE, 16'h10FF, 16'h3004, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

        reset = 1'b1;
        req_valid = 1'b0;
        req_valid1 = 1'b0;
        cmd_ready = 1'b1;
        drive_fields(vt[0].r);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("reset_cmd_data", 32'(cmd_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            model(vt[i].r);
            exp_q.delete();
            for (int k = 0; k < vt[i].n; k++) exp_q.push_back(vt[i].w[k]);
            send_req(vt[i].r);
            wait_idle();
            compare_got($sformatf("vec%0d", i));
        end

        // Abort during XFER; the reissued request must start with DLEN again.
        r = '{3'd1, 2'b01, 12'd600, 8'h20, 2'd0, 8'h00, 8'h77};
        model(r);
        send_req(r);
        t = 0;
        while (!(cmd_valid && cmd_data[15:8] == 8'h01) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("reached_xfer", 32'(cmd_data[15:8]), 32'h01);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        mc_vld = 1'b0;
        got_q.delete();
        model(r);
        send_req(r);
        wait_idle();
        chk("after_reset_first_dlen", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h2220);
        compare_got("after_reset");

        // Single chip-select instance: out-of-range select yields just SYNC.
        r = '{3'd3, 2'b01, 12'd4, 8'h08, 2'd0, 8'h05, 8'h11};
        got1_q.delete();
        t = 0;
        while (!req_ready1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        drive_fields(r);
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        t = 0;
        while (busy1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("cs1_busy_done", 32'(busy1), 32'd0);
        chk("cs1_len", 32'(got1_q.size()), 32'd1);
        chk("cs1_word", (got1_q.size() > 0) ? 32'(got1_q[0]) : 32'hDEAD, 32'h3011);

        stall_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            int wsel;
            r.sel   = 3'($urandom_range(0, 5));
            r.dir   = 2'($urandom_range(0, 3));
            wsel    = $urandom_range(0, 5);
            r.words = (wsel == 0) ? 12'd0 : (wsel == 1) ? 12'd256 : (wsel == 2) ? 12'd257 :
                      12'($urandom_range(1, 900));
            r.dlen  = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'($urandom);
            r.delay = 2'($urandom_range(0, 3));
            r.sleep = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            r.id    = 8'($urandom);
            model(r);
            send_req(r);
            wait_idle();
            compare_got($sformatf("rand%0d", i));
        end
        stall_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_engine_cmd_builder.md
Name: spi_engine_cmd_builder

Overview:
- Upstream command generator for the SPI Engine execution core.
- Accepts one high-level transfer request over a valid/ready port and expands it into a 16-bit SPI Engine instruction stream on a valid/ready command port.
- Per-request instruction order: DLENGTH, CS assert, transfer chunk(s), SLEEP, CS deassert, SYNC.
- Used in HDL designs and test benches in place of hand-written instruction sequences.

Parameters:
- NUM_OF_CS, 1, number of chip selects in use (1..8).
- WORDS_W, 12, width of the req_words field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_cs_sel  in  3  chip-select index
- req_dir  in  2  transfer type: 00 none, 01 write, 10 read, 11 write+read
- req_words  in  WORDS_W  number of words to transfer
- req_dlength  in  8  data length in bits
- req_cs_delay  in  2  CS delay field
- req_sleep  in  8  sleep count; 0 means no SLEEP instruction
- req_sync_id  in  8  SYNC argument
- cmd_valid  out  1  instruction valid
- cmd_ready  in  1  execution core ready
- cmd_data  out  16  instruction word
- busy  out  1  high from request accept until SYNC handshake completes

Behaviour:
- Clock and reset: one clock `clk`; reset `reset`, synchronous, active-high.
- Reset values: req_ready=0 for the reset cycle, then 1 in IDLE; cmd_valid=0; cmd_data=0; busy=0; DLENGTH cache invalid; FSM=IDLE.
- Request acceptance:
  - req_ready=1 only in IDLE.
  - On accept, all request fields are latched.
  - First instruction is presented on the next cycle.
- Output handshake:
  - cmd_data and cmd_valid are registered.
  - cmd_data is held stable while cmd_valid && !cmd_ready.
  - One instruction is transferred per cmd_valid && cmd_ready cycle; back-to-back transfers run with no bubbles.
- FSM states: IDLE -> [CFG -> PRESCALE] -> DLEN -> CS_ON -> XFER -> SLEEP -> CS_OFF -> SYNC -> IDLE.
  - Each state advances on the handshake of its instruction.
  - Skipped states cost no cycles.
- Encodings:
  - DLEN = 0x2200 | dlength.
  - CS = 0x1000 | (delay<<8) | mask.
  - XFER = (dir<<8) | (n-1).
  - SLEEP = 0x3100 | sleep.
  - SYNC = 0x3000 | id.
- CS masks: CS_ON mask = ~(1<<sel) & 0xFF. CS_OFF mask = 0xFF. Both use req_cs_delay.
- DLEN:
  - Emitted only when dir != 00 and (cache invalid or dlength != cached value).
  - The cache is updated on the DLEN handshake.
- XFER chunking:
  - remaining = req_words.
  - While remaining > 256, emit n-1=0xFF and subtract 256.
  - The final chunk emits remaining-1.
  - XFER is skipped when dir==00 or req_words==0.
- SLEEP: skipped when req_sleep==0.
- Invalid CS: if req_cs_sel >= NUM_OF_CS, DLEN/CS_ON/XFER/SLEEP/CS_OFF are all skipped; only SYNC is emitted.
- Reset mid-operation: the FSM aborts to IDLE, cmd_valid drops in the following cycle, and the DLENGTH cache is invalidated. No CS deassert is emitted; the downstream core is reset alongside.
- Requests arriving while busy are stalled (req_ready=0), never dropped.

Optional Feature:
- SPI_CMD_BUILDER_CFG_EN defined:
  - Adds ports cfg_cpol, cfg_cpha, cfg_three_wire, cfg_sdo_idle (1 bit each) and cfg_prescale (8).
  - Every accepted request first emits CFG = 0x2100 | (sdo_idle<<3) | (three_wire<<2) | (cpol<<1) | cpha.
  - CFG is followed by PRESCALE = 0x2000 | prescale.
  - The cfg inputs are sampled at request accept.
- Undefined: the cfg ports and the CFG/PRESCALE states are absent.

Decomposition:
- Shared package spi_engine_cmd_pkg holds:
  - Opcode localparams: CS 0x10, CFG 0x21, PRESCALE 0x20, DLEN 0x22, SYNC 0x30, SLEEP 0x31, WR/RD/WRD 0x01/0x02/0x03.
  - The FSM state enum typedef.
  - The dir typedef.
- Sub-module spi_engine_cmd_chunker: holds the remaining-word counter and produces per-chunk n-1 and the last-chunk flag.

Test Plan:
- sel=0, dir=01, words=4, dlen=8, delay=0, sleep=0, id=0x5A, cmd_ready=1 -> 0x2208, 0x10FE, 0x0103, 0x10FF, 0x305A. busy falls after SYNC.
- Same request repeated -> DLEN omitted: 0x10FE, 0x0103, 0x10FF, 0x305A.
- dir=11, words=600, dlen=16, sel=2, delay=1, sleep=3 (NUM_OF_CS=4) -> 0x2210, 0x11FB, 0x03FF, 0x03FF, 0x0357, 0x3103, 0x11FF, 0x30xx.
- Random cmd_ready stalls (~50%) -> cmd_data held stable on every stall; sequence identical to the zero-stall run.
- NUM_OF_CS=1, sel=3, id=0x11 -> only 0x3011 emitted.
- Reset asserted during XFER, then a new request -> fresh sequence starting with DLEN (cache invalidated).
